// File: rtl/bp_fe_mem_requester.sv
// FE memory requester: issues fetch/fill/fence commands, tracks the 2-stage fetch pipeline, replays on miss.
// Optional per-kind miss counters are enabled by defining BP_FE_MEM_REQUESTER_PERF_EN.
module bp_fe_mem_requester #(
    parameter int vaddr_width_p = 39,
    parameter int vtag_width_p  = 27,
    parameter int ptag_width_p  = 28,
    parameter int instr_width_p = 32,
    localparam int tlb_entry_width_lp = ptag_width_p + 4,
    localparam int mem_cmd_width_lp   = 2 + vaddr_width_p + vtag_width_p + tlb_entry_width_lp,
    localparam int mem_resp_width_lp  = 4 + instr_width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          redirect_v_i,
    input  logic [vaddr_width_p-1:0]      redirect_vaddr_i,
    input  logic                          fill_v_i,
    input  logic [vtag_width_p-1:0]       fill_vtag_i,
    input  logic [tlb_entry_width_lp-1:0] fill_entry_i,
    output logic                          fill_yumi_o,
    input  logic                          fence_v_i,
    input  logic                          fence_icache_i,
    output logic                          fence_yumi_o,
    output logic [mem_cmd_width_lp-1:0]   mem_cmd_o,
    output logic                          mem_cmd_v_o,
    input  logic                          mem_cmd_yumi_i,
    output logic                          mem_poison_o,
    input  logic [mem_resp_width_lp-1:0]  mem_resp_i,
    input  logic                          mem_resp_v_i,
    output logic [instr_width_p-1:0]      fetch_o,
    output logic [vaddr_width_p-1:0]      fetch_pc_o,
    output logic                          fetch_v_o,
    input  logic                          fetch_ready_i,
    output logic                          itlb_miss_o,
    output logic                          exc_v_o,
    output logic [1:0]                    exc_code_o,
    output logic [vaddr_width_p-1:0]      exc_vaddr_o
`ifdef BP_FE_MEM_REQUESTER_PERF_EN
    ,
    output logic [31:0]                   icache_miss_cnt_o,
    output logic [31:0]                   itlb_miss_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, TLB_WAIT, FAULT} state_e;
    typedef enum logic [1:0] {
        OP_FETCH        = 2'd0,
        OP_TLB_FILL     = 2'd1,
        OP_ICACHE_FENCE = 2'd2,
        OP_TLB_FENCE    = 2'd3
    } mem_op_e;

    localparam logic [vaddr_width_p-1:0] pc_step_lp = vaddr_width_p'(4);

    state_e                   state;
    logic [vaddr_width_p-1:0] pc, s1_pc, s2_pc, exc_vaddr_r;
    logic                     s1_v, s2_v;
    logic [1:0]               exc_code_r;

    // Response layout, MSB first: access fault, page fault, itlb miss, icache miss, data
    logic                     resp_access_fault, resp_page_fault, resp_itlb_miss, resp_icache_miss;
    logic [instr_width_p-1:0] resp_data;
    assign {resp_access_fault, resp_page_fault, resp_itlb_miss, resp_icache_miss, resp_data} = mem_resp_i;

    logic resp_live, resp_bad, resp_clean, cmd_accept;
    assign resp_live  = mem_resp_v_i & s2_v & ~redirect_v_i;
    assign resp_bad   = resp_live & (resp_access_fault | resp_page_fault | resp_itlb_miss
                                     | resp_icache_miss | ~fetch_ready_i);
    assign resp_clean = resp_live & ~resp_bad;

    mem_op_e                       cmd_op;
    logic [vaddr_width_p-1:0]      cmd_vaddr;
    logic [vtag_width_p-1:0]       cmd_vtag;
    logic [tlb_entry_width_lp-1:0] cmd_entry;

    // A bad response or a redirect suppresses the command in the same cycle it is seen
    always_comb begin
        mem_cmd_v_o = 1'b0;
        cmd_op      = OP_FETCH;
        cmd_vaddr   = '0;
        cmd_vtag    = '0;
        cmd_entry   = '0;
        if (!redirect_v_i) begin
            case (state)
                IDLE: if (fence_v_i && !s1_v && !s2_v) begin
                    mem_cmd_v_o = 1'b1;
                    cmd_op      = fence_icache_i ? OP_ICACHE_FENCE : OP_TLB_FENCE;
                end
                RUN: begin
                    mem_cmd_v_o = ~resp_bad;
                    cmd_vaddr   = pc;
                end
                TLB_WAIT: if (fill_v_i) begin
                    mem_cmd_v_o = 1'b1;
                    cmd_op      = OP_TLB_FILL;
                    cmd_vtag    = fill_vtag_i;
                    cmd_entry   = fill_entry_i;
                end
                default: ;
            endcase
        end
    end

    assign cmd_accept   = mem_cmd_v_o & mem_cmd_yumi_i;
    assign mem_cmd_o    = mem_cmd_v_o ? {cmd_op, cmd_vaddr, cmd_vtag, cmd_entry} : '0;
    assign fence_yumi_o = cmd_accept & (state == IDLE);
    assign fill_yumi_o  = cmd_accept & (state == TLB_WAIT);
    assign mem_poison_o = redirect_v_i | resp_bad;

    assign fetch_v_o    = resp_clean;
    assign fetch_o      = resp_clean ? resp_data : '0;
    assign fetch_pc_o   = resp_clean ? s2_pc : '0;

    assign itlb_miss_o  = (state == TLB_WAIT);
    assign exc_v_o      = (state == FAULT);
    assign exc_code_o   = exc_code_r;
    assign exc_vaddr_o  = exc_vaddr_r;

    // Pipeline stages only advance in RUN; elsewhere nothing is in flight
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            pc          <= '0;
            s1_pc       <= '0;
            s2_pc       <= '0;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            exc_code_r  <= 2'b00;
            exc_vaddr_r <= '0;
        end else if (redirect_v_i) begin
            state <= RUN;
            pc    <= redirect_vaddr_i;
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
        end else begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            case (state)
                RUN: begin
                    s1_v  <= cmd_accept;
                    s2_v  <= s1_v & ~mem_poison_o;
                    s2_pc <= s1_pc;
                    if (cmd_accept) begin
                        s1_pc <= pc;
                        pc    <= pc + pc_step_lp;
                    end
                    if (resp_bad) begin
                        if (resp_access_fault) begin
                            exc_code_r  <= 2'b01;
                            exc_vaddr_r <= s2_pc;
                            state       <= FAULT;
                        end else if (resp_page_fault) begin
                            exc_code_r  <= 2'b10;
                            exc_vaddr_r <= s2_pc;
                            state       <= FAULT;
                        end else if (resp_itlb_miss) begin
                            pc          <= s2_pc;
                            exc_vaddr_r <= s2_pc;
                            state       <= TLB_WAIT;
                        end else begin
                            pc <= s2_pc;
                        end
                    end
                end
                TLB_WAIT: if (cmd_accept) state <= RUN;
                FAULT:    state <= IDLE;
                default:  ;
            endcase
        end
    end

`ifdef BP_FE_MEM_REQUESTER_PERF_EN
    logic icache_miss_evt, itlb_miss_evt;
    assign itlb_miss_evt   = resp_bad & resp_itlb_miss & ~resp_access_fault & ~resp_page_fault;
    assign icache_miss_evt = resp_bad & resp_icache_miss & ~resp_itlb_miss
                             & ~resp_access_fault & ~resp_page_fault;

    // Saturating counters; only reset clears them
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            icache_miss_cnt_o <= '0;
            itlb_miss_cnt_o   <= '0;
        end else begin
            if (icache_miss_evt && icache_miss_cnt_o != 32'hFFFF_FFFF)
                icache_miss_cnt_o <= icache_miss_cnt_o + 32'd1;
            if (itlb_miss_evt && itlb_miss_cnt_o != 32'hFFFF_FFFF)
                itlb_miss_cnt_o <= itlb_miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_mem_requester.sv
// Directed bench for bp_fe_mem_requester; a small 2-stage memory-stage stand-in returns responses.
module tb_bp_fe_mem_requester;

    localparam int VW = 39;
    localparam int VTW = 27;
    localparam int PTW = 28;
    localparam int IW = 32;
    localparam int EW = PTW + 4;
    localparam int CW = 2 + VW + VTW + EW;
    localparam int RW = 4 + IW;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic           redirect_v_i;
    logic [VW-1:0]  redirect_vaddr_i;
    logic           fill_v_i;
    logic [VTW-1:0] fill_vtag_i;
    logic [EW-1:0]  fill_entry_i;
    logic           fill_yumi_o;
    logic           fence_v_i;
    logic           fence_icache_i;
    logic           fence_yumi_o;
    logic [CW-1:0]  mem_cmd_o;
    logic           mem_cmd_v_o;
    logic           mem_cmd_yumi_i;
    logic           mem_poison_o;
    logic [RW-1:0]  mem_resp_i;
    logic           mem_resp_v_i;
    logic [IW-1:0]  fetch_o;
    logic [VW-1:0]  fetch_pc_o;
    logic           fetch_v_o;
    logic           fetch_ready_i;
    logic           itlb_miss_o;
    logic           exc_v_o;
    logic [1:0]     exc_code_o;
    logic [VW-1:0]  exc_vaddr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_mem_requester #(
        .vaddr_width_p(VW), .vtag_width_p(VTW), .ptag_width_p(PTW), .instr_width_p(IW)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .redirect_v_i(redirect_v_i), .redirect_vaddr_i(redirect_vaddr_i),
        .fill_v_i(fill_v_i), .fill_vtag_i(fill_vtag_i), .fill_entry_i(fill_entry_i),
        .fill_yumi_o(fill_yumi_o),
        .fence_v_i(fence_v_i), .fence_icache_i(fence_icache_i), .fence_yumi_o(fence_yumi_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_poison_o(mem_poison_o), .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i),
        .fetch_o(fetch_o), .fetch_pc_o(fetch_pc_o), .fetch_v_o(fetch_v_o),
        .fetch_ready_i(fetch_ready_i), .itlb_miss_o(itlb_miss_o),
        .exc_v_o(exc_v_o), .exc_code_o(exc_code_o), .exc_vaddr_o(exc_vaddr_o)
    );

    wire [1:0]     cmd_op    = mem_cmd_o[CW-1 -: 2];
    wire [VW-1:0]  cmd_vaddr = mem_cmd_o[CW-3 -: VW];
    wire [VTW-1:0] cmd_vtag  = mem_cmd_o[EW +: VTW];
    wire [EW-1:0]  cmd_entry = mem_cmd_o[EW-1:0];

    // Memory-stage stand-in: accepted fetches respond two cycles later unless poisoned in stage 1
    logic          ms1_v, ms2_v, inj_spurious;
    logic [VW-1:0] ms1_pc, ms2_pc;
    logic [3:0]    inj;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ms1_v  <= 1'b0;
            ms2_v  <= 1'b0;
            ms1_pc <= '0;
            ms2_pc <= '0;
        end else begin
            ms1_v  <= mem_cmd_v_o & mem_cmd_yumi_i & (cmd_op == 2'd0);
            ms1_pc <= cmd_vaddr;
            ms2_v  <= ms1_v & ~mem_poison_o;
            ms2_pc <= ms1_pc;
        end
    end

    assign mem_resp_v_i = ms2_v | inj_spurious;
    assign mem_resp_i   = {inj, ms2_pc[31:0] ^ 32'hC0DE_0000};

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [VW-1:0] rvaddr, input logic fill,
                                 input logic ready, input logic [3:0] injv);
        @(posedge clk_i);
        #1;
        redirect_v_i     = redir;
        redirect_vaddr_i = rvaddr;
        fill_v_i         = fill;
        fetch_ready_i    = ready;
        inj              = injv;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'h0);
    endtask

    task automatic redirectTo(input logic [VW-1:0] target);
        applyStimulus(1'b1, target, 1'b0, 1'b1, 4'h0);
    endtask

    initial begin
        reset_n_i = 1'b0; redirect_v_i = 1'b0; redirect_vaddr_i = '0;
        fill_v_i = 1'b0; fill_vtag_i = 27'h123_4567; fill_entry_i = 32'hDEAD_BEEF;
        fence_v_i = 1'b0; fence_icache_i = 1'b0; mem_cmd_yumi_i = 1'b1;
        fetch_ready_i = 1'b1; inj = 4'h0; inj_spurious = 1'b0;
        #12;
        checkOutput("rst_cmd_v", mem_cmd_v_o, 0);
        checkOutput("rst_fetch_v", fetch_v_o, 0);
        checkOutput("rst_poison", mem_poison_o, 0);
        checkOutput("rst_exc_v", exc_v_o, 0);
        checkOutput("rst_itlb_miss", itlb_miss_o, 0);
        checkOutput("rst_exc_vaddr", exc_vaddr_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // IDLE: no fetches, spurious response ignored, fences issued
        inj_spurious = 1'b1;
        idleCycle();
        checkOutput("idle_cmd_v", mem_cmd_v_o, 0);
        checkOutput("spurious_fetch_v", fetch_v_o, 0);
        checkOutput("spurious_poison", mem_poison_o, 0);
        inj_spurious = 1'b0;
        fence_v_i = 1'b1; fence_icache_i = 1'b1;
        idleCycle();
        checkOutput("fence_ic_v", mem_cmd_v_o, 1);
        checkOutput("fence_ic_op", cmd_op, 2);
        checkOutput("fence_ic_yumi", fence_yumi_o, 1);
        fence_icache_i = 1'b0; mem_cmd_yumi_i = 1'b0;
        idleCycle();
        checkOutput("fence_tlb_op", cmd_op, 3);
        checkOutput("fence_noyumi", fence_yumi_o, 0);
        fence_v_i = 1'b0; mem_cmd_yumi_i = 1'b1;

        // Sequential fetch stream after redirect
        redirectTo(39'h8000_0000);
        checkOutput("redir_poison", mem_poison_o, 1);
        checkOutput("redir_cmd_v", mem_cmd_v_o, 0);
        idleCycle();
        checkOutput("seq_cmd_v", mem_cmd_v_o, 1);
        checkOutput("seq_cmd_op", cmd_op, 0);
        checkOutput("seq_cmd0", cmd_vaddr, 39'h8000_0000);
        idleCycle();
        checkOutput("seq_cmd1", cmd_vaddr, 39'h8000_0004);
        checkOutput("seq_early_fetch_v", fetch_v_o, 0);
        idleCycle();
        checkOutput("seq_fetch0_v", fetch_v_o, 1);
        checkOutput("seq_fetch0_pc", fetch_pc_o, 39'h8000_0000);
        checkOutput("seq_fetch0_data", fetch_o, 32'h40DE_0000);
        idleCycle();
        checkOutput("seq_fetch1_pc", fetch_pc_o, 39'h8000_0004);
        idleCycle();
        checkOutput("seq_fetch2_pc", fetch_pc_o, 39'h8000_0008);

        // icache miss on 0x8000_0004: poison, replay from that PC
        redirectTo(39'h8000_0000);
        idleCycle(); idleCycle(); idleCycle();
        checkOutput("icm_fetch0_pc", fetch_pc_o, 39'h8000_0000);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'b0001);
        checkOutput("icm_poison", mem_poison_o, 1);
        checkOutput("icm_cmd_v", mem_cmd_v_o, 0);
        checkOutput("icm_fetch_v", fetch_v_o, 0);
        idleCycle();
        checkOutput("icm_replay_cmd", cmd_vaddr, 39'h8000_0004);
        checkOutput("icm_gap_fetch_v", fetch_v_o, 0);
        idleCycle();
        checkOutput("icm_gap2_fetch_v", fetch_v_o, 0);
        idleCycle();
        checkOutput("icm_replay_pc", fetch_pc_o, 39'h8000_0004);
        idleCycle();
        checkOutput("icm_next_pc", fetch_pc_o, 39'h8000_0008);

        // itlb miss at 0x4000: wait for fill, then replay
        redirectTo(39'h4000);
        idleCycle(); idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'b0010);
        checkOutput("itlb_poison", mem_poison_o, 1);
        checkOutput("itlb_fetch_v", fetch_v_o, 0);
        idleCycle();
        checkOutput("itlb_miss_lvl", itlb_miss_o, 1);
        checkOutput("itlb_miss_vaddr", exc_vaddr_o, 39'h4000);
        checkOutput("itlb_wait_cmd_v", mem_cmd_v_o, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'h0);
        checkOutput("fill_cmd_v", mem_cmd_v_o, 1);
        checkOutput("fill_cmd_op", cmd_op, 1);
        checkOutput("fill_cmd_vtag", cmd_vtag, 27'h123_4567);
        checkOutput("fill_cmd_entry", cmd_entry, 32'hDEAD_BEEF);
        checkOutput("fill_yumi", fill_yumi_o, 1);
        idleCycle();
        checkOutput("fill_done_miss", itlb_miss_o, 0);
        checkOutput("fill_replay_cmd", cmd_vaddr, 39'h4000);
        checkOutput("fill_replay_op", cmd_op, 0);
        idleCycle(); idleCycle();
        checkOutput("fill_replay_pc", fetch_pc_o, 39'h4000);
        checkOutput("fill_replay_data", fetch_o, 32'hC0DE_4000);

        // Redirect during TLB_WAIT overrides the fill
        redirectTo(39'h5000);
        idleCycle(); idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'b0010);
        idleCycle();
        checkOutput("tw_miss_lvl", itlb_miss_o, 1);
        applyStimulus(1'b1, 39'h6000, 1'b1, 1'b1, 4'h0);
        checkOutput("tw_redir_fill_yumi", fill_yumi_o, 0);
        checkOutput("tw_redir_cmd_v", mem_cmd_v_o, 0);
        idleCycle();
        checkOutput("tw_redir_miss", itlb_miss_o, 0);
        checkOutput("tw_redir_cmd", cmd_vaddr, 39'h6000);

        // Access fault beats page fault; then IDLE with no commands
        redirectTo(39'h2000);
        idleCycle(); idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'b1100);
        checkOutput("af_poison", mem_poison_o, 1);
        checkOutput("af_exc_early", exc_v_o, 0);
        idleCycle();
        checkOutput("af_exc_v", exc_v_o, 1);
        checkOutput("af_exc_code", exc_code_o, 2'b01);
        checkOutput("af_exc_vaddr", exc_vaddr_o, 39'h2000);
        checkOutput("af_cmd_v", mem_cmd_v_o, 0);
        idleCycle();
        checkOutput("af_exc_pulse", exc_v_o, 0);
        checkOutput("af_idle_cmd_v", mem_cmd_v_o, 0);
        idleCycle();
        checkOutput("af_idle_cmd_v2", mem_cmd_v_o, 0);

        // Page fault beats itlb miss
        redirectTo(39'h3000);
        idleCycle(); idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'b0110);
        idleCycle();
        checkOutput("pf_exc_v", exc_v_o, 1);
        checkOutput("pf_exc_code", exc_code_o, 2'b10);
        checkOutput("pf_exc_vaddr", exc_vaddr_o, 39'h3000);
        checkOutput("pf_itlb_miss", itlb_miss_o, 0);

        // Backpressure on a clean response at 0x100
        redirectTo(39'h100);
        idleCycle(); idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'h0);
        checkOutput("bp_poison", mem_poison_o, 1);
        checkOutput("bp_fetch_v", fetch_v_o, 0);
        idleCycle();
        checkOutput("bp_replay_cmd", cmd_vaddr, 39'h100);
        idleCycle(); idleCycle();
        checkOutput("bp_replay_v", fetch_v_o, 1);
        checkOutput("bp_replay_pc", fetch_pc_o, 39'h100);

        // Redirect with a response and fill_v in the same cycle
        applyStimulus(1'b1, 39'h600, 1'b1, 1'b1, 4'h0);
        checkOutput("rr_fetch_v", fetch_v_o, 0);
        checkOutput("rr_poison", mem_poison_o, 1);
        checkOutput("rr_fill_yumi", fill_yumi_o, 0);
        checkOutput("rr_cmd_v", mem_cmd_v_o, 0);
        idleCycle();
        checkOutput("rr_next_cmd", cmd_vaddr, 39'h600);
        checkOutput("rr_next_op", cmd_op, 0);

        // Back-to-back redirects: last wins
        redirectTo(39'h900);
        redirectTo(39'hA00);
        idleCycle();
        checkOutput("b2b_cmd", cmd_vaddr, 39'hA00);

        // PC wraps at the top of the address space
        redirectTo(39'h7F_FFFF_FFFC);
        idleCycle();
        checkOutput("wrap_cmd0", cmd_vaddr, 39'h7F_FFFF_FFFC);
        idleCycle();
        checkOutput("wrap_cmd1", cmd_vaddr, 39'h0);

        // Reset mid-stream abandons everything at once
        #1;
        reset_n_i = 1'b0;
        #1;
        checkOutput("midrst_cmd_v", mem_cmd_v_o, 0);
        checkOutput("midrst_fetch_v", fetch_v_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        idleCycle();
        checkOutput("midrst_idle_cmd_v", mem_cmd_v_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
